// File: rtl/mfp_ahb_sevenseg_updater.sv
`default_nettype none
// ============================================================================
// Module   : mfp_ahb_sevenseg_updater
// Purpose  : AHB-Lite initiator that writes a display image (enables, digits,
//            decimal points) into the seven-segment slave as single NONSEQ
//            word writes, with pipelined address/data phases.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_ahb_sevenseg_updater #(
    parameter logic [31:0] BASE_ADDR = 32'h1F70_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_mask,
    input  logic [7:0]  req_ens,
    input  logic [63:0] req_digits,
    input  logic [7:0]  req_dp,
    output logic        done,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] c_HSIZE_WORD    = 3'b010;
    localparam logic [2:0] c_HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_DATA = 3'd2,
        S_DATA      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_rem, w_rem_nxt;
    logic [1:0]  r_cur_idx, w_cur_idx_nxt;
    logic [7:0]  r_ens, r_dp;
    logic [63:0] r_digits;
    logic [31:0] r_haddr, w_haddr_nxt;
    logic [31:0] r_hwdata, w_hwdata_nxt;
    logic [1:0]  r_htrans, w_htrans_nxt;
    logic        r_err, w_err_nxt;
    logic        w_accept;
    logic [1:0]  w_first_idx, w_next_idx;
    logic [31:0] w_cur_word;

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [31:0] reg_addr(input logic [1:0] idx);
        return BASE_ADDR + {28'd0, idx, 2'b00};
    endfunction

    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_first_idx = lowest_idx(req_mask);
    assign w_next_idx  = lowest_idx(r_rem);

    // Write data for the transfer whose address phase is currently on the bus
    always_comb begin
        w_cur_word = 32'd0;
        case (r_cur_idx)
            2'd0:    w_cur_word = {24'd0, r_ens};
            2'd1:    w_cur_word = r_digits[63:32];
            2'd2:    w_cur_word = r_digits[31:0];
            default: w_cur_word = {24'd0, r_dp};
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rem_nxt     = r_rem;
        w_cur_idx_nxt = r_cur_idx;
        w_haddr_nxt   = r_haddr;
        w_hwdata_nxt  = r_hwdata;
        w_htrans_nxt  = r_htrans;
        w_err_nxt     = r_err;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_err_nxt = 1'b0;
                    if (req_mask == 4'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt   = S_ADDR;
                        w_htrans_nxt  = c_HTRANS_NONSEQ;
                        w_haddr_nxt   = reg_addr(w_first_idx);
                        w_cur_idx_nxt = w_first_idx;
                        w_rem_nxt     = req_mask & ~(4'b0001 << w_first_idx);
                    end
                end
            end
            S_ADDR, S_ADDR_DATA: begin
                if (HRESP && (r_state == S_ADDR_DATA)) begin
                    // Error on the previous data phase: cancel the pending address
                    w_htrans_nxt = c_HTRANS_IDLE;
                    w_rem_nxt    = 4'd0;
                    if (HREADY) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else if (HREADY) begin
                    w_hwdata_nxt = w_cur_word;
                    if (r_rem != 4'd0) begin
                        w_state_nxt   = S_ADDR_DATA;
                        w_haddr_nxt   = reg_addr(w_next_idx);
                        w_cur_idx_nxt = w_next_idx;
                        w_rem_nxt     = r_rem & ~(4'b0001 << w_next_idx);
                    end else begin
                        w_state_nxt  = S_DATA;
                        w_htrans_nxt = c_HTRANS_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    w_err_nxt   = r_err | HRESP;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_htrans_nxt = c_HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_rem     <= 4'd0;
            r_cur_idx <= 2'd0;
            r_ens     <= 8'd0;
            r_dp      <= 8'd0;
            r_digits  <= 64'd0;
            r_haddr   <= BASE_ADDR;
            r_hwdata  <= 32'd0;
            r_htrans  <= c_HTRANS_IDLE;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_cur_idx <= w_cur_idx_nxt;
            r_haddr   <= w_haddr_nxt;
            r_hwdata  <= w_hwdata_nxt;
            r_htrans  <= w_htrans_nxt;
            r_err     <= w_err_nxt;
            if (w_accept) begin
                r_ens    <= req_ens;
                r_dp     <= req_dp;
                r_digits <= req_digits;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) && r_err;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_htrans[1];
    assign HSIZE     = c_HSIZE_WORD;
    assign HBURST    = c_HBURST_SINGLE;
    assign HWDATA    = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_mfp_ahb_sevenseg_updater.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfp_ahb_sevenseg_updater
// Purpose  : Self-checking bench with an AHB slave/monitor and a table-driven
//            model of the expected register writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_ahb_sevenseg_updater;

    localparam logic [31:0] c_BASE = 32'h1F70_0000;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_mask = 4'd0;
    logic [7:0]  req_ens = 8'd0;
    logic [63:0] req_digits = 64'd0;
    logic [7:0]  req_dp = 8'd0;
    logic        done, err;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_sevenseg_updater #(.BASE_ADDR(c_BASE)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_mask(req_mask),
        .req_ens(req_ens), .req_digits(req_digits), .req_dp(req_dp),
        .done(done), .err(err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Slave / monitor state
    bit          dp_valid, rand_wait;
    logic [31:0] dp_addr;
    int          dp_idx, err_phase, err_xfer, stall_xfer, stall_left, waits;
    logic [31:0] got_aaddr[$], got_daddr[$], got_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] stall_haddr[$], stall_hwdata[$];
    int          done_cnt, done_cyc, first_ns_cyc, nonseq_cnt, viol, accept_cyc;
    bit          done_err, done_ready, p_ready, p_errfirst, p_dpv;
    logic [1:0]  htrans_after_err, p_htrans;
    logic [31:0] p_haddr, p_hwdata;

    task automatic clear_mon();
        dp_valid = 0; dp_idx = 0; err_phase = 0; err_xfer = -1; stall_xfer = -1;
        stall_left = 0; rand_wait = 0; waits = 0;
        got_aaddr.delete(); got_daddr.delete(); got_data.delete();
        stall_haddr.delete(); stall_hwdata.delete();
        done_cnt = 0; done_cyc = -1; first_ns_cyc = -1; nonseq_cnt = 0; viol = 0;
        done_err = 0; done_ready = 0; htrans_after_err = 2'b11;
        p_ready = 1; p_errfirst = 0; p_dpv = 0;
    endtask

    // One clock: drive slave response, then observe the bus for this cycle
    task automatic step();
        bit errfirst, dpv_before;
        @(negedge HCLK);
        cyc++;
        errfirst = 0;
        dpv_before = dp_valid;
        HRESP = 1'b0;
        HREADY = 1'b1;
        if (dp_valid) begin
            if (dp_idx == err_xfer) begin
                HRESP = 1'b1;
                if (err_phase == 0) begin
                    HREADY = 1'b0; err_phase = 1; errfirst = 1;
                end
            end else if (dp_idx == stall_xfer && stall_left > 0) begin
                HREADY = 1'b0;
                stall_left--;
                stall_haddr.push_back(HADDR);
                stall_hwdata.push_back(HWDATA);
            end else if (rand_wait && $urandom_range(3) == 0) begin
                HREADY = 1'b0;
            end
        end
        if (!HREADY) waits++;
        if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HWRITE !== (HTRANS == 2'b10) ||
            (HTRANS !== 2'b00 && HTRANS !== 2'b10)) viol++;
        if (p_errfirst) htrans_after_err = HTRANS;
        if (!p_ready && !p_errfirst) begin
            if (p_htrans == 2'b10 && (HTRANS !== p_htrans || HADDR !== p_haddr)) viol++;
            if (p_dpv && HWDATA !== p_hwdata) viol++;
        end
        if (HTRANS == 2'b10) begin
            nonseq_cnt++;
            if (first_ns_cyc < 0) first_ns_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++; done_cyc = cyc; done_err = err; done_ready = req_ready;
        end else if (err === 1'b1) begin
            viol++;
        end
        if (dp_valid && HREADY) begin
            got_daddr.push_back(dp_addr);
            got_data.push_back(HWDATA);
            dp_idx++;
            dp_valid = 0;
            err_phase = 0;
        end
        if (HREADY && HTRANS == 2'b10) begin
            got_aaddr.push_back(HADDR);
            dp_valid = 1;
            dp_addr = HADDR;
        end
        p_ready = HREADY; p_errfirst = errfirst; p_dpv = dpv_before;
        p_htrans = HTRANS; p_haddr = HADDR; p_hwdata = HWDATA;
    endtask

    // Reference: register map as a table, writes in ascending address order
    task automatic build_expected(input logic [3:0] m, input logic [7:0] e,
                                  input logic [63:0] d, input logic [7:0] p);
        logic [31:0] words [4];
        words[0] = {24'h0, e};
        words[1] = d[63:32];
        words[2] = d[31:0];
        words[3] = {24'h0, p};
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < 4; i++)
            if (m[i]) begin
                exp_addr.push_back(c_BASE + 32'(4 * i));
                exp_data.push_back(words[i]);
            end
    endtask

    function automatic bit writes_match();
        if (got_daddr.size() != exp_addr.size() || got_aaddr.size() != exp_addr.size()) return 0;
        foreach (exp_addr[i])
            if (got_daddr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] ||
                got_aaddr[i] !== exp_addr[i]) return 0;
        return 1;
    endfunction

    task automatic run_seq(input logic [3:0] m, input logic [7:0] e, input logic [63:0] d,
                           input logic [7:0] p, input bit hold);
        int budget;
        budget = 0;
        while (req_ready !== 1'b1 && budget < 20) begin step(); budget++; end
        req_mask = m; req_ens = e; req_digits = d; req_dp = p; req_valid = 1'b1;
        accept_cyc = cyc;
        step();
        if (!hold) begin
            req_valid = 1'b0;
            req_mask = 4'($urandom); req_ens = 8'($urandom);
            req_digits = {$urandom, $urandom}; req_dp = 8'($urandom);
        end
        budget = 0;
        while (done_cnt == 0 && budget < 200) begin step(); budget++; end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) step();
        n_checks++; if (HTRANS !== 2'b00) begin n_errors++; $display("FAIL rst_htrans: got %0h want 0", HTRANS); end
        n_checks++; if (HWRITE !== 1'b0) begin n_errors++; $display("FAIL rst_hwrite: got %0b want 0", HWRITE); end
        n_checks++; if (HADDR !== c_BASE) begin n_errors++; $display("FAIL rst_haddr: got %h want %h", HADDR, c_BASE); end
        n_checks++; if (HWDATA !== 32'd0) begin n_errors++; $display("FAIL rst_hwdata: got %h want 0", HWDATA); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL rst_done_err: got %b%b want 00", done, err); end
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        HRESET = 1'b0;
        step();
    endtask

    task automatic test_full();
        clear_mon();
        build_expected(4'hF, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'h7F);
        run_seq(4'hF, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'h7F, 0);
        n_checks++; if (writes_match() !== 1'b1) begin n_errors++; $display("FAIL full_writes: got %0d writes want %0d", got_daddr.size(), exp_addr.size()); end
        n_checks++; if (first_ns_cyc != accept_cyc + 1) begin n_errors++; $display("FAIL full_first_ns: got +%0d want +1", first_ns_cyc - accept_cyc); end
        n_checks++; if (nonseq_cnt != 4) begin n_errors++; $display("FAIL full_nonseq_cnt: got %0d want 4", nonseq_cnt); end
        n_checks++; if (done_cyc != accept_cyc + 6) begin n_errors++; $display("FAIL full_done_cycle: got +%0d want +6", done_cyc - accept_cyc); end
        n_checks++; if (done_err !== 1'b0) begin n_errors++; $display("FAIL full_err: got %b want 0", done_err); end
        n_checks++; if (done_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready_in_done: got %b want 0", done_ready); end
        step();
        n_checks++; if (done !== 1'b0 || done_cnt != 1) begin n_errors++; $display("FAIL full_done_pulse: got done=%b cnt=%0d want 0/1", done, done_cnt); end
        n_checks++; if (viol != 0) begin n_errors++; $display("FAIL full_bus_rules: got %0d violations want 0", viol); end
    endtask

    task automatic test_sparse();
        logic [63:0] d;
        logic [7:0] e, p;
        clear_mon();
        d = {$urandom, $urandom}; e = 8'($urandom); p = 8'($urandom);
        build_expected(4'b0101, e, d, p);
        run_seq(4'b0101, e, d, p, 0);
        n_checks++; if (writes_match() !== 1'b1) begin n_errors++; $display("FAIL sparse_writes: got %0d writes want %0d", got_daddr.size(), exp_addr.size()); end
        n_checks++; if (nonseq_cnt != 2) begin n_errors++; $display("FAIL sparse_nonseq_cnt: got %0d want 2", nonseq_cnt); end
        n_checks++; if (done_cyc != accept_cyc + 4) begin n_errors++; $display("FAIL sparse_done_cycle: got +%0d want +4", done_cyc - accept_cyc); end
    endtask

    task automatic test_stall();
        bit held;
        clear_mon();
        stall_xfer = 1; stall_left = 3;
        build_expected(4'hF, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'h7F);
        run_seq(4'hF, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'h7F, 0);
        held = (stall_haddr.size() == 3);
        foreach (stall_haddr[i])
            if (stall_haddr[i] !== c_BASE + 32'h8 || stall_hwdata[i] !== 32'h0123_4567) held = 0;
        n_checks++; if (held !== 1'b1) begin n_errors++; $display("FAIL stall_hold: got %0d good stall cycles want 3 at %h/%h", stall_haddr.size(), c_BASE + 32'h8, 32'h0123_4567); end
        n_checks++; if (writes_match() !== 1'b1) begin n_errors++; $display("FAIL stall_writes: got %0d writes want %0d", got_daddr.size(), exp_addr.size()); end
        n_checks++; if (done_cyc != accept_cyc + 9) begin n_errors++; $display("FAIL stall_done_cycle: got +%0d want +9", done_cyc - accept_cyc); end
        n_checks++; if (viol != 0) begin n_errors++; $display("FAIL stall_bus_rules: got %0d violations want 0", viol); end
    endtask

    task automatic test_error();
        clear_mon();
        err_xfer = 1;
        build_expected(4'hF, 8'h3C, 64'hDEAD_BEEF_CAFE_F00D, 8'h81);
        run_seq(4'hF, 8'h3C, 64'hDEAD_BEEF_CAFE_F00D, 8'h81, 0);
        n_checks++; if (got_aaddr.size() != 2 || got_daddr.size() != 2 || got_daddr[1] !== exp_addr[1] || got_data[1] !== exp_data[1])
            begin n_errors++; $display("FAIL err_transfers: got %0d addr/%0d data phases want 2/2", got_aaddr.size(), got_daddr.size()); end
        n_checks++; if (htrans_after_err !== 2'b00) begin n_errors++; $display("FAIL err_cancel: got HTRANS %0h want 0", htrans_after_err); end
        n_checks++; if (nonseq_cnt != 3) begin n_errors++; $display("FAIL err_nonseq_cnt: got %0d want 3", nonseq_cnt); end
        n_checks++; if (done_cnt != 1 || done_err !== 1'b1) begin n_errors++; $display("FAIL err_flag: got cnt=%0d err=%b want 1/1", done_cnt, done_err); end
        n_checks++; if (done_cyc != accept_cyc + 5) begin n_errors++; $display("FAIL err_done_cycle: got +%0d want +5", done_cyc - accept_cyc); end
        step();
        n_checks++; if (done !== 1'b0 || err !== 1'b0 || viol != 0) begin n_errors++; $display("FAIL err_pulse: got done=%b err=%b viol=%0d want 0/0/0", done, err, viol); end
    endtask

    task automatic test_reset_mid();
        int b;
        clear_mon();
        b = 0;
        while (req_ready !== 1'b1 && b < 20) begin step(); b++; end
        req_mask = 4'hF; req_ens = 8'h11; req_digits = 64'h1111_2222_3333_4444; req_dp = 8'h22;
        req_valid = 1'b1;
        accept_cyc = cyc;
        step();
        req_valid = 1'b0;
        while (cyc < accept_cyc + 3) step();
        n_checks++; if (HTRANS !== 2'b10 || HADDR !== c_BASE + 32'h8) begin n_errors++; $display("FAIL rmid_third: got %0h@%h want 2@%h", HTRANS, HADDR, c_BASE + 32'h8); end
        HRESET = 1'b1;
        step();
        n_checks++; if (HTRANS !== 2'b00 || req_ready !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL rmid_abort: got htrans=%0h ready=%b done=%b want 0/1/0", HTRANS, req_ready, done); end
        HRESET = 1'b0;
        clear_mon();
        repeat (3) step();
        n_checks++; if (done_cnt != 0 || nonseq_cnt != 0) begin n_errors++; $display("FAIL rmid_quiet: got done=%0d nonseq=%0d want 0/0", done_cnt, nonseq_cnt); end
        clear_mon();
        build_expected(4'h8, 8'h55, 64'h0, 8'hA5);
        run_seq(4'h8, 8'h55, 64'h0, 8'hA5, 0);
        n_checks++; if (writes_match() !== 1'b1) begin n_errors++; $display("FAIL rmid_new_writes: got %0d writes want 1", got_daddr.size()); end
        n_checks++; if (done_cyc != accept_cyc + 3 || done_err !== 1'b0) begin n_errors++; $display("FAIL rmid_new_done: got +%0d err=%b want +3/0", done_cyc - accept_cyc, done_err); end
    endtask

    task automatic test_mask_zero();
        clear_mon();
        run_seq(4'h0, 8'($urandom), {$urandom, $urandom}, 8'($urandom), 1);
        n_checks++; if (done_cyc != accept_cyc + 1 || done_err !== 1'b0) begin n_errors++; $display("FAIL zero_done: got +%0d err=%b want +1/0", done_cyc - accept_cyc, done_err); end
        step();
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL zero_reaccept_ready: got %b want 1", req_ready); end
        step();
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL zero_reaccept_done: got %b want 1", done); end
        req_valid = 1'b0;
        step();
        n_checks++; if (nonseq_cnt != 0) begin n_errors++; $display("FAIL zero_no_bus: got %0d NONSEQ want 0", nonseq_cnt); end
    endtask

    task automatic test_random();
        logic [3:0]  m;
        logic [7:0]  e, p;
        logic [63:0] d;
        int n, want;
        for (int it = 0; it < 25; it++) begin
            clear_mon();
            rand_wait = 1;
            m = 4'($urandom); e = 8'($urandom); p = 8'($urandom); d = {$urandom, $urandom};
            build_expected(m, e, d, p);
            run_seq(m, e, d, p, 0);
            n = $countones(m);
            want = (n == 0) ? 1 : n + 2 + waits;
            n_checks++; if (writes_match() !== 1'b1) begin n_errors++; $display("FAIL rand_writes[%0d]: mask %h got %0d writes want %0d", it, m, got_daddr.size(), exp_addr.size()); end
            n_checks++; if (done_cyc != accept_cyc + want || done_err !== 1'b0) begin n_errors++; $display("FAIL rand_done[%0d]: got +%0d err=%b want +%0d/0", it, done_cyc - accept_cyc, done_err, want); end
            n_checks++; if (viol != 0) begin n_errors++; $display("FAIL rand_bus_rules[%0d]: got %0d violations want 0", it, viol); end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_full();
        test_sparse();
        test_stall();
        test_error();
        test_reset_mid();
        test_mask_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
